// File: rtl/conv_window_addr_gen_pkg.sv
// Shared constants, FSM encoding and beat payload for the 3x3 window address generator.
package conv_window_addr_gen_pkg;

  localparam int unsigned MEM_W = 80;
  localparam int unsigned MEM_H = 8;
  localparam int unsigned WB    = 7;
  localparam int unsigned HB    = 3;
  localparam int unsigned NTAP  = 9;

  localparam logic [NTAP-1:0] EN_ALL = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Tap t sits at offset (TAP_DC[t], TAP_DR[t]) from the window centre.
  localparam int TAP_DC [NTAP] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int TAP_DR [NTAP] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  typedef struct packed {
    logic [WB*NTAP-1:0] readi_w;
    logic [HB*NTAP-1:0] readi_h;
    logic [NTAP-1:0]    en_read;
  } beat_t;

  // Output width/height parity equals tile width/height parity in both pad modes.
  function automatic logic cfg_legal(input logic [WB:0] w, input logic [HB:0] h,
                                     input logic mp);
    return (w >= (WB+1)'(3)) && (w <= (WB+1)'(MEM_W)) &&
           (h >= (HB+1)'(3)) && (h <= (HB+1)'(MEM_H)) &&
           !(mp && (w[0] || h[0]));
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_tap_decode.sv
// Combinational 3x3 tap decode: centre plus tile bounds to packed addresses and enable mask.
module conv_window_addr_gen_tap_decode
  import conv_window_addr_gen_pkg::*;
(
  input  logic [WB-1:0]      i_cen_col,
  input  logic [HB-1:0]      i_cen_row,
  input  logic [WB:0]        i_width,
  input  logic [HB:0]        i_height,
  output logic [WB*NTAP-1:0] o_readi_w_c,
  output logic [HB*NTAP-1:0] o_readi_h_c,
  output logic [NTAP-1:0]    o_en_read_c
);

  localparam int unsigned CW = WB + 2;
  localparam int unsigned RW = HB + 2;

  logic signed [CW-1:0] w_col [NTAP];
  logic signed [RW-1:0] w_row [NTAP];
  logic [NTAP-1:0]      w_en;

  // Tap 0 lands in the MSB field; taps outside the tile are masked and zeroed.
  always_comb begin
    w_en        = EN_ALL;
    o_readi_w_c = '0;
    o_readi_h_c = '0;
    for (int unsigned t = 0; t < NTAP; t++) begin
      w_col[t] = $signed({2'b00, i_cen_col}) + CW'(TAP_DC[t]);
      w_row[t] = $signed({2'b00, i_cen_row}) + RW'(TAP_DR[t]);
      if (w_col[t][CW-1] || (w_col[t] >= $signed({1'b0, i_width})) ||
          w_row[t][RW-1] || (w_row[t] >= $signed({1'b0, i_height}))) begin
        w_en[NTAP-1-t] = 1'b0;
      end else begin
        o_readi_w_c[WB*(NTAP-1-t) +: WB] = w_col[t][WB-1:0];
        o_readi_h_c[HB*(NTAP-1-t) +: HB] = w_row[t][HB-1:0];
      end
    end
  end

  assign o_en_read_c = w_en;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Feature-map tile walker: emits one 3x3 window (addresses, pad mask, maxpool marker) per beat.
module conv_window_addr_gen
  import conv_window_addr_gen_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WB:0]        i_cfg_width,
  input  logic [HB:0]        i_cfg_height,
  input  logic               i_cfg_pad,
  input  logic               i_cfg_mp,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [WB*NTAP-1:0] o_readi_w,
  output logic [HB*NTAP-1:0] o_readi_h,
  output logic [NTAP-1:0]    o_en_read,
  output logic               o_quad_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err
);

  state_e        r_state, w_state_nxt;
  logic [WB:0]   r_width, w_width_nxt;
  logic [HB:0]   r_height, w_height_nxt;
  logic          r_pad, w_pad_nxt;
  logic          r_mp, w_mp_nxt;
  logic [WB-1:0] r_col_end, w_col_end_nxt;
  logic [HB-1:0] r_row_end, w_row_end_nxt;
  logic [WB-1:0] r_col, w_col_nxt;
  logic [HB-1:0] r_row, w_row_nxt;
  logic [1:0]    r_q, w_q_nxt;
  logic          r_valid, w_valid_nxt;
  beat_t         r_beat, w_beat_nxt;
  logic          r_quad_last, w_quad_last_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_cfg_err, w_cfg_err_nxt;

  logic          w_cfg_ok;
  logic [WB:0]   w_ow;
  logic [HB:0]   w_oh;
  logic          w_q_wrap;
  logic          w_last;
  logic [WB-1:0] w_adv_col;
  logic [HB-1:0] w_adv_row;
  logic [1:0]    w_adv_q;
  logic [WB-1:0] w_sel_col;
  logic [HB-1:0] w_sel_row;
  logic [1:0]    w_sel_q;
  logic          w_sel_pad;
  logic [WB:0]   w_sel_width;
  logic [HB:0]   w_sel_height;
  logic [WB-1:0] w_cen_col;
  logic [HB-1:0] w_cen_row;
  beat_t         w_dec_beat;

  assign w_cfg_ok = cfg_legal(i_cfg_width, i_cfg_height, i_cfg_mp);
  assign w_ow     = i_cfg_pad ? i_cfg_width  : i_cfg_width  - (WB+1)'(2);
  assign w_oh     = i_cfg_pad ? i_cfg_height : i_cfg_height - (HB+1)'(2);

  // Position step: quad index fastest in maxpool mode, then column (pair), then row (pair).
  assign w_q_wrap = !r_mp || (r_q == 2'd3);
  assign w_last   = w_q_wrap && (r_col == r_col_end) && (r_row == r_row_end);

  always_comb begin
    w_adv_col = r_col;
    w_adv_row = r_row;
    w_adv_q   = r_q;
    if (!w_q_wrap) begin
      w_adv_q = r_q + 2'd1;
    end else begin
      w_adv_q = 2'd0;
      if (r_col == r_col_end) begin
        w_adv_col = '0;
        w_adv_row = r_row + HB'(1) + HB'(r_mp);
      end else begin
        w_adv_col = r_col + WB'(1) + WB'(r_mp);
      end
    end
  end

  // Idle decodes beat 0 straight from the live cfg so it registers on the start edge.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_col    = '0;
      w_sel_row    = '0;
      w_sel_q      = '0;
      w_sel_pad    = i_cfg_pad;
      w_sel_width  = i_cfg_width;
      w_sel_height = i_cfg_height;
    end else begin
      w_sel_col    = w_adv_col;
      w_sel_row    = w_adv_row;
      w_sel_q      = w_adv_q;
      w_sel_pad    = r_pad;
      w_sel_width  = r_width;
      w_sel_height = r_height;
    end
  end

  assign w_cen_col = w_sel_col + WB'(w_sel_q[1]) + WB'(!w_sel_pad);
  assign w_cen_row = w_sel_row + HB'(w_sel_q[0]) + HB'(!w_sel_pad);

  conv_window_addr_gen_tap_decode u_tap_decode (
    .i_cen_col   (w_cen_col),
    .i_cen_row   (w_cen_row),
    .i_width     (w_sel_width),
    .i_height    (w_sel_height),
    .o_readi_w_c (w_dec_beat.readi_w),
    .o_readi_h_c (w_dec_beat.readi_h),
    .o_en_read_c (w_dec_beat.en_read)
  );

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_width_nxt     = r_width;
    w_height_nxt    = r_height;
    w_pad_nxt       = r_pad;
    w_mp_nxt        = r_mp;
    w_col_end_nxt   = r_col_end;
    w_row_end_nxt   = r_row_end;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_q_nxt         = r_q;
    w_valid_nxt     = r_valid;
    w_beat_nxt      = r_beat;
    w_quad_last_nxt = r_quad_last;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_cfg_err_nxt   = r_cfg_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cfg_err_nxt = !w_cfg_ok;
          if (w_cfg_ok) begin
            w_state_nxt     = S_RUN;
            w_width_nxt     = i_cfg_width;
            w_height_nxt    = i_cfg_height;
            w_pad_nxt       = i_cfg_pad;
            w_mp_nxt        = i_cfg_mp;
            w_col_end_nxt   = WB'(w_ow - ((WB+1)'(1) + (WB+1)'(i_cfg_mp)));
            w_row_end_nxt   = HB'(w_oh - ((HB+1)'(1) + (HB+1)'(i_cfg_mp)));
            w_col_nxt       = '0;
            w_row_nxt       = '0;
            w_q_nxt         = '0;
            w_valid_nxt     = 1'b1;
            w_beat_nxt      = w_dec_beat;
            w_quad_last_nxt = !i_cfg_mp;
            w_busy_nxt      = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_valid && i_out_ready) begin
          if (w_last) begin
            w_state_nxt     = S_DONE;
            w_valid_nxt     = 1'b0;
            w_beat_nxt      = '0;
            w_quad_last_nxt = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_col_nxt       = w_adv_col;
            w_row_nxt       = w_adv_row;
            w_q_nxt         = w_adv_q;
            w_beat_nxt      = w_dec_beat;
            w_quad_last_nxt = !r_mp || (w_adv_q == 2'd3);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_height    <= '0;
      r_pad       <= 1'b0;
      r_mp        <= 1'b0;
      r_col_end   <= '0;
      r_row_end   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_q         <= '0;
      r_valid     <= 1'b0;
      r_beat      <= '0;
      r_quad_last <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_width     <= w_width_nxt;
      r_height    <= w_height_nxt;
      r_pad       <= w_pad_nxt;
      r_mp        <= w_mp_nxt;
      r_col_end   <= w_col_end_nxt;
      r_row_end   <= w_row_end_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_q         <= w_q_nxt;
      r_valid     <= w_valid_nxt;
      r_beat      <= w_beat_nxt;
      r_quad_last <= w_quad_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
    end
  end

  assign o_out_valid = r_valid;
  assign o_readi_w   = r_beat.readi_w;
  assign o_readi_h   = r_beat.readi_h;
  assign o_en_read   = r_beat.en_read;
  assign o_quad_last = r_quad_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: window model per tile walk, decoupled monitor.
module tb_conv_window_addr_gen;

  localparam int WB = 7;
  localparam int HB = 3;
  localparam int NT = 9;

  typedef struct packed {
    logic [WB*NT-1:0] rw;
    logic [HB*NT-1:0] rh;
    logic [NT-1:0]    en;
    logic             ql;
    logic             fin;
  } sb_t;

  logic              i_clk;
  logic              i_reset;
  logic              i_start;
  logic [WB:0]       i_cfg_width;
  logic [HB:0]       i_cfg_height;
  logic              i_cfg_pad;
  logic              i_cfg_mp;
  logic              i_out_ready;
  logic              o_out_valid;
  logic [WB*NT-1:0]  o_readi_w;
  logic [HB*NT-1:0]  o_readi_h;
  logic [NT-1:0]     o_en_read;
  logic              o_quad_last;
  logic              o_busy;
  logic              o_done;
  logic              o_cfg_err;

  conv_window_addr_gen dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_cfg_width  (i_cfg_width),
    .i_cfg_height (i_cfg_height),
    .i_cfg_pad    (i_cfg_pad),
    .i_cfg_mp     (i_cfg_mp),
    .i_out_ready  (i_out_ready),
    .o_out_valid  (o_out_valid),
    .o_readi_w    (o_readi_w),
    .o_readi_h    (o_readi_h),
    .o_en_read    (o_en_read),
    .o_quad_last  (o_quad_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err)
  );

  int  checks;
  int  failures;
  sb_t sb_q[$];
  sb_t cap_q[$];
  sb_t ref_q[$];
  bit  rnd_ready;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One output window computed straight from the tap geometry rules.
  function automatic sb_t make_beat(int w, int h, int pad, int oc, int orow);
    sb_t b;
    int  cc, cr, t, col, row;
    b  = '0;
    cc = oc + (pad != 0 ? 0 : 1);
    cr = orow + (pad != 0 ? 0 : 1);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        t   = 3 * (dr + 1) + (dc + 1);
        col = cc + dc;
        row = cr + dr;
        if (col >= 0 && col < w && row >= 0 && row < h) begin
          b.en[8-t]            = 1'b1;
          b.rw[WB*(8-t) +: WB] = WB'(col);
          b.rh[HB*(8-t) +: HB] = HB'(row);
        end
      end
    end
    return b;
  endfunction

  function automatic int push_walk(int w, int h, int pad, int mp);
    int  ow, oh, n;
    sb_t b;
    ow = (pad != 0) ? w : w - 2;
    oh = (pad != 0) ? h : h - 2;
    n  = 0;
    if (mp != 0) begin
      for (int r = 0; r < oh; r += 2)
        for (int c = 0; c < ow; c += 2)
          for (int k = 0; k < 4; k++) begin
            b     = make_beat(w, h, pad, c + k / 2, r + k % 2);
            b.ql  = (k == 3);
            b.fin = (r == oh - 2) && (c == ow - 2) && (k == 3);
            sb_q.push_back(b);
            n++;
          end
    end else begin
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          b     = make_beat(w, h, pad, c, r);
          b.ql  = 1'b1;
          b.fin = (r == oh - 1) && (c == ow - 1);
          sb_q.push_back(b);
          n++;
        end
    end
    return n;
  endfunction

  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall hold and done timing.
  initial begin
    sb_t cur, prev, exp;
    bit  prev_stall, exp_done;
    prev = '0; prev_stall = 0; exp_done = 0;
    forever begin
      @(negedge i_clk);
      cur = '{rw: o_readi_w, rh: o_readi_h, en: o_en_read, ql: o_quad_last, fin: 1'b0};
      if (i_reset) begin
        prev_stall = 0;
        exp_done   = 0;
      end else begin
        if (exp_done || o_done) chk("done_pulse", 128'(o_done), 128'(exp_done));
        exp_done = 0;
        if (prev_stall) begin
          chk("stall_valid", 128'(o_out_valid), 128'(1));
          chk("stall_hold", 128'(cur), 128'(prev));
        end
        if (o_out_valid && i_out_ready) begin
          chk("busy_with_beat", 128'(o_busy), 128'(1));
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat actual=beat required=none en=%0h", o_en_read);
          end else begin
            exp = sb_q.pop_front();
            chk("beat_readi_w", 128'(cur.rw), 128'(exp.rw));
            chk("beat_readi_h", 128'(cur.rh), 128'(exp.rh));
            chk("beat_en_read", 128'(cur.en), 128'(exp.en));
            chk("beat_quad_last", 128'(cur.ql), 128'(exp.ql));
            exp_done = exp.fin;
          end
          cap_q.push_back(cur);
        end
        prev_stall = o_out_valid && !i_out_ready;
        prev       = cur;
      end
    end
  end

  task automatic scramble_cfg();
    i_cfg_width  = (WB+1)'($urandom_range(0, 255));
    i_cfg_height = (HB+1)'($urandom_range(0, 15));
    i_cfg_pad    = 1'($urandom_range(0, 1));
    i_cfg_mp     = 1'($urandom_range(0, 1));
  endtask

  task automatic start_walk(input int w, input int h, input int pad, input int mp,
                            input bit rnd, output int n);
    n = push_walk(w, h, pad, mp);
    cap_q.delete();
    @(posedge i_clk);
    #1;
    rnd_ready    = rnd;
    i_cfg_width  = (WB+1)'(w);
    i_cfg_height = (HB+1)'(h);
    i_cfg_pad    = 1'(pad);
    i_cfg_mp     = 1'(mp);
    i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    scramble_cfg();
    @(negedge i_clk);
    chk("first_valid", 128'(o_out_valid), 128'(1));
    chk("busy_on", 128'(o_busy), 128'(1));
    chk("cfg_err_clear", 128'(o_cfg_err), 128'(0));
  endtask

  task automatic wait_done(input int budget, input int n);
    int cyc;
    bit seen;
    cyc = 0; seen = 0;
    while (!seen && cyc < budget) begin
      @(negedge i_clk);
      if (o_done) seen = 1;
      cyc++;
    end
    chk("walk_done_seen", 128'(seen), 128'(1));
    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    chk("beat_count", 128'(cap_q.size()), 128'(n));
    sb_q.delete();
    @(negedge i_clk);
    chk("busy_off", 128'(o_busy), 128'(0));
    chk("cfg_err_low", 128'(o_cfg_err), 128'(0));
  endtask

  task automatic run_walk(input int w, input int h, input int pad, input int mp,
                          input bit rnd, input bit poke);
    int n;
    start_walk(w, h, pad, mp, rnd, n);
    if (poke) begin
      repeat (2) @(posedge i_clk);
      #1;
      i_cfg_width  = (WB+1)'(5);
      i_cfg_height = (HB+1)'(4);
      i_cfg_pad    = 1'b1;
      i_cfg_mp     = 1'b1;
      i_start      = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
    end
    wait_done(4 * n + 20, n);
  endtask

  task automatic run_bad(input int w, input int h, input int pad, input int mp);
    @(posedge i_clk);
    #1;
    i_cfg_width  = (WB+1)'(w);
    i_cfg_height = (HB+1)'(h);
    i_cfg_pad    = 1'(pad);
    i_cfg_mp     = 1'(mp);
    i_start      = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    scramble_cfg();
    @(negedge i_clk);
    chk("cfg_err_set", 128'(o_cfg_err), 128'(1));
    repeat (4) begin
      chk("bad_no_valid", 128'(o_out_valid), 128'(0));
      chk("bad_no_busy", 128'(o_busy), 128'(0));
      @(negedge i_clk);
    end
    chk("cfg_err_sticky", 128'(o_cfg_err), 128'(1));
  endtask

  initial begin
    logic [WB*NT-1:0] exp_rw;
    logic [HB*NT-1:0] exp_rh;
    int               w, h, pad, mp, ow, oh, cyc, n;
    bit               legal;
    checks = 0; failures = 0; rnd_ready = 0;
    i_reset = 1'b1; i_start = 1'b0;
    i_cfg_width = '0; i_cfg_height = '0; i_cfg_pad = 1'b0; i_cfg_mp = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", 128'({o_out_valid, o_readi_w, o_readi_h, o_en_read, o_quad_last,
                               o_busy, o_done, o_cfg_err}), 128'(0));
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // 4x4 padded maxpool walk
    run_walk(4, 4, 1, 1, 0, 0);
    if (cap_q.size() == 16) begin
      chk("mp_beat0_en", 128'(cap_q[0].en), 128'(9'b000011011));
      chk("mp_beat1_en", 128'(cap_q[1].en), 128'(9'b011011011));
      for (int i = 0; i < 16; i++) chk("mp_quad_last", 128'(cap_q[i].ql), 128'(i % 4 == 3));
    end

    // 4x4 valid conv walk
    run_walk(4, 4, 0, 0, 0, 0);
    exp_rw = '0; exp_rh = '0;
    for (int t = 0; t < NT; t++) begin
      exp_rw[WB*(8-t) +: WB] = WB'(t % 3);
      exp_rh[HB*(8-t) +: HB] = HB'(t / 3);
    end
    if (cap_q.size() == 4) begin
      chk("nopad_beat0_rw", 128'(cap_q[0].rw), 128'(exp_rw));
      chk("nopad_beat0_rh", 128'(cap_q[0].rh), 128'(exp_rh));
      for (int i = 0; i < 4; i++) chk("nopad_en_all", 128'(cap_q[i].en), 128'(9'h1FF));
    end

    // Full-size walk, then the same under random backpressure
    run_walk(80, 8, 1, 0, 0, 0);
    if (cap_q.size() == 640) begin
      chk("last_en", 128'(cap_q[639].en), 128'(9'b110110000));
      chk("last_tap0_col", 128'(cap_q[639].rw[WB*9-1 -: WB]), 128'(78));
      chk("last_tap0_row", 128'(cap_q[639].rh[HB*9-1 -: HB]), 128'(6));
    end
    ref_q = cap_q;
    run_walk(80, 8, 1, 0, 1, 0);
    chk("stall_run_len", 128'(cap_q.size()), 128'(ref_q.size()));
    if (cap_q.size() == ref_q.size()) begin
      n = 0;
      for (int i = 0; i < cap_q.size(); i++) if (cap_q[i] !== ref_q[i]) n++;
      chk("stall_run_same_seq", 128'(n), 128'(0));
    end

    // Illegal cfg, then start while busy must be ignored
    run_bad(5, 4, 1, 1);
    run_walk(6, 8, 0, 1, 1, 1);
    run_bad(2, 4, 1, 0);
    run_walk(3, 3, 0, 0, 0, 0);

    // Random configurations
    for (int it = 0; it < 16; it++) begin
      w   = $urandom_range(1, 84);
      h   = $urandom_range(1, 9);
      pad = $urandom_range(0, 1);
      mp  = $urandom_range(0, 1);
      ow  = (pad != 0) ? w : w - 2;
      oh  = (pad != 0) ? h : h - 2;
      legal = (w >= 3) && (w <= 80) && (h >= 3) && (h <= 8) &&
              ((mp == 0) || ((ow % 2 == 0) && (oh % 2 == 0)));
      if (legal) run_walk(w, h, pad, mp, 1'($urandom_range(0, 1)), (ow * oh) >= 8);
      else       run_bad(w, h, pad, mp);
    end

    // Reset in the middle of a walk
    start_walk(4, 4, 1, 1, 0, n);
    cyc = 0;
    while (cap_q.size() < 5 && cyc < 50) begin
      @(posedge i_clk);
      cyc++;
    end
    chk("reached_beat5", 128'(cap_q.size() >= 5), 128'(1));
    #1;
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("midwalk_reset_outputs", 128'({o_out_valid, o_readi_w, o_readi_h, o_en_read, o_quad_last,
                                       o_busy, o_done, o_cfg_err}), 128'(0));
    sb_q.delete();
    cap_q.delete();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("no_done_after_abort", 128'(o_done), 128'(0));
    end
    run_walk(4, 4, 1, 1, 0, 0);
    if (cap_q.size() == 16) chk("rewalk_beat0_en", 128'(cap_q[0].en), 128'(9'b000011011));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
